rom_rr_read_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port synchronous-read ROM (w=8, d=16) between N requesters. Each requester presents an address with a valid/ready handshake. The arbiter issues at most one address per cycle to the ROM port and tracks the requester ID through the ROM's one-cycle read latency. It returns registered read data with a per-requester response pulse, sitting between client blocks and the ROM instance.

---
 rtl/rom_rr_read_arbiter.sv | 109 ++++++++++
 tb/tb_rom_rr_read_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rom_rr_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM port between N requesters.
// Issues one address per clock and tracks the requester ID through the ROM read latency.
module rom_rr_read_arbiter #(
  parameter int w  = 8,
  parameter int d  = 16,
  parameter int N  = 4,
  localparam int AW = $clog2(d),
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_vld,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    req_rdy,
  output logic [AW-1:0]   rom_addr,
  input  logic [w-1:0]    rom_data,
  output logic [N-1:0]    rsp_vld,
  output logic [w-1:0]    rsp_data,
  output logic [IW-1:0]   rsp_id,
  output logic            busy
);

  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          s1_v_q, s1_v_d;
  logic [IW-1:0] s1_id_q, s1_id_d;
  logic          s2_v_q, s2_v_d;
  logic [IW-1:0] s2_id_q, s2_id_d;
  logic [N-1:0]  rsp_vld_q, rsp_vld_d;
  logic [w-1:0]  rsp_data_q, rsp_data_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;

  logic          grant;
  logic [IW-1:0] win;

  // Rotating search starting at the priority pointer; first active requester wins.
  always_comb begin
    int idx;
    grant   = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!grant && req_vld[idx]) begin
        grant = 1'b1;
        win   = IW'(idx);
      end
    end
    req_rdy = '0;
    if (grant && rst_n) req_rdy[win] = 1'b1;
  end

  // Stage E0: issue address; E1: ROM read in flight; E2: capture response.
  always_comb begin
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    s1_id_d    = s1_id_q;
    s1_v_d     = grant;
    if (grant) begin
      rom_addr_d = req_addr[win*AW +: AW];
      ptr_d      = (win == IW'(N-1)) ? '0 : win + 1'b1;
      s1_id_d    = win;
    end

    s2_v_d  = s1_v_q;
    s2_id_d = s1_id_q;

    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (s2_v_q) begin
      rsp_vld_d[s2_id_q] = 1'b1;
      rsp_data_d         = rom_data;
      rsp_id_d           = s2_id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      ptr_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_id_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_id_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      ptr_q      <= ptr_d;
      s1_v_q     <= s1_v_d;
      s1_id_q    <= s1_id_d;
      s2_v_q     <= s2_v_d;
      s2_id_q    <= s2_id_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;
  assign busy     = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_rom_rr_read_arbiter.sv
// Scoreboard bench for rom_rr_read_arbiter: directed scenarios plus random traffic
// against a round-robin reference model and a behavioural ROM (data = A0 + addr).
module tb_rom_rr_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_vld = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_rdy;
  logic [AW-1:0]   rom_addr;
  logic [7:0]      rom_data;
  logic [N-1:0]    rsp_vld;
  logic [7:0]      rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  rom_rr_read_arbiter #(.w(8), .d(16), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_addr(req_addr),
    .req_rdy(req_rdy), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= 8'hA0 + {4'h0, rom_addr};

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int         mptr = 0;
  bit         g1 = 0, g2 = 0;
  logic [3:0] rom_exp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model and response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    int   win;
    bit   gnt;
    logic [3:0] a;
    logic [N-1:0] rdy_exp;
    if (!rst_n) begin
      chk("rst_req_rdy", 32'(req_rdy), 0);
      chk("rst_rsp_vld", 32'(rsp_vld), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      q.delete();
      mptr = 0; g1 = 0; g2 = 0; rom_exp = '0;
    end else begin
      if (rsp_vld != '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_vld), 0);
        end else begin
          e = q.pop_front();
          chk("rsp_vld", 32'(rsp_vld), 32'(1) << e.id);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("rsp_missing", 32'(rsp_vld), 32'(1) << e.id);
      end
      chk("busy", 32'(busy), 32'(g1 | g2));
      chk("rom_addr", 32'(rom_addr), 32'(rom_exp));

      gnt = 0; win = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (!gnt && req_vld[i]) begin gnt = 1; win = i; end
      end
      rdy_exp = '0;
      if (gnt) rdy_exp[win] = 1'b1;
      chk("req_rdy", 32'(req_rdy), 32'(rdy_exp));
      if (gnt) begin
        a = req_addr[win*AW +: AW];
        e.id = win; e.data = 8'hA0 + {4'h0, a}; e.due = cyc + 3;
        q.push_back(e);
        rom_exp = a;
        mptr = (win + 1) % N;
      end
      g2 = g1; g1 = gnt;
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a, input int n);
    req_vld = v; req_addr = a;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive('0, '0, 3);
    // Single requester 2 reading address 5.
    drive(4'b0100, 16'h0500, 1);
    drive('0, '0, 4);
    // All four requesting, requester i at address i+8.
    drive(4'b1111, 16'hBA98, 8);
    drive('0, '0, 3);
    // Requester 1 alone moves the pointer to 2, then 1 and 3 alternate across the wrap.
    drive(4'b0010, 16'h0040, 1);
    drive(4'b1010, 16'hC030, 5);
    drive('0, '0, 3);
    // Sole requester 0 streams addresses 0..15.
    for (int i = 0; i < 16; i++) drive(4'b0001, 16'(i), 1);
    drive('0, '0, 4);
    // Reset one cycle after a grant, with that read in flight.
    drive(4'b0010, 16'h0070, 1);
    rst_n = 1'b0; req_vld = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive('0, '0, 4);
    drive(4'b1010, 16'h9020, 3);
    drive('0, '0, 3);
    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0; req_vld = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        drive(N'($urandom_range(0, 15)), 16'($urandom), 1);
      end
    end
    drive('0, '0, 6);
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
